bht_controller: RTL

//  Owns the branch history table (BHT) of 2-bit saturating predictors. Serves one

---
 rtl/bp_pkg.sv | 37 +++
 rtl/bp_sat_counter.sv | 14 +
 rtl/bht_controller.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: default widths, 2-bit counter encoding
// and the saturating-counter transition function.
package bp_pkg;

  localparam int unsigned BP_PC_W    = 32;
  localparam int unsigned BP_IDX_W   = 6;
  localparam int unsigned BP_TAG_W   = 8;
  localparam int unsigned BP_CNT_W   = 16;
  localparam int unsigned BP_ST_W    = 2;
  localparam int unsigned BP_IDX_LSB = 2;

  typedef enum logic [BP_ST_W-1:0] {
    BP_NTS = 2'b00,
    BP_NTW = 2'b01,
    BP_TW  = 2'b10,
    BP_TS  = 2'b11
  } bp_state_e;

  // Weakly-not-taken jumps straight to strongly-taken on a taken outcome.
  function automatic bp_state_e bp_next_state(input bp_state_e state, input logic taken);
    bp_state_e nxt;
    nxt = state;
    if (taken) begin
      case (state)
        BP_NTS:  nxt = BP_NTW;
        default: nxt = BP_TS;
      endcase
    end else begin
      case (state)
        BP_TS:   nxt = BP_TW;
        default: nxt = BP_NTS;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state of one 2-bit saturating branch predictor entry.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [BP_ST_W-1:0] cur_state,
  input  logic               taken,
  output logic [BP_ST_W-1:0] next_state
);

  always_comb begin
    next_state = BP_ST_W'(bp_next_state(bp_state_e'(cur_state), taken));
  end

endmodule

// File: rtl/bht_controller.sv
// Branch history table controller: IF lookup with update forwarding, EX update
// pipeline, mispredict redirect and statistics. BHT_BTB_EN adds a tagged BTB.
module bht_controller
  import bp_pkg::*;
#(
  parameter int unsigned PC_W  = BP_PC_W,
  parameter int unsigned IDX_W = BP_IDX_W,
  parameter int unsigned TAG_W = BP_TAG_W,
  parameter int unsigned CNT_W = BP_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [BP_ST_W-1:0] bht_q [ENTRIES];
  logic [BP_ST_W-1:0] bht_d [ENTRIES];

  logic               upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0]   upd_idx_q, upd_idx_d;
  logic               upd_taken_q, upd_taken_d;
  logic               upd_mis_q, upd_mis_d;
  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;

  logic [IDX_W-1:0]   if_idx;
  logic [IDX_W-1:0]   ex_idx;
  logic [BP_ST_W-1:0] upd_cur, upd_next;
  logic [BP_ST_W-1:0] lk_cur, fwd_next, lk_state;
  logic               fwd_hit;
  logic               mispredict;
  logic               unused_pc_bits;

  assign if_idx  = if_pc[IDX_W+BP_IDX_LSB-1:BP_IDX_LSB];
  assign ex_idx  = ex_pc[IDX_W+BP_IDX_LSB-1:BP_IDX_LSB];
  assign upd_cur = bht_q[upd_idx_q];
  assign lk_cur  = bht_q[if_idx];
  assign unused_pc_bits = ^{if_pc, ex_pc};

  bp_sat_counter u_upd_cnt (
    .cur_state  (upd_cur),
    .taken      (upd_taken_q),
    .next_state (upd_next)
  );

  // Forwarding path: same transition applied to the entry IF is reading.
  bp_sat_counter u_fwd_cnt (
    .cur_state  (lk_cur),
    .taken      (upd_taken_q),
    .next_state (fwd_next)
  );

  assign fwd_hit  = upd_valid_q & (if_idx == upd_idx_q);
  assign lk_state = fwd_hit ? fwd_next : lk_cur;

  assign mispredict = ex_valid & ((ex_taken != ex_pred_taken) |
                      (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));

  always_comb begin
    upd_valid_d = ex_valid;
    upd_idx_d   = ex_idx;
    upd_taken_d = ex_taken;
    upd_mis_d   = mispredict;
  end

  // Table write and statistics retire the pending update on the same edge.
  always_comb begin
    bht_d     = bht_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd_valid_q) begin
      bht_d[upd_idx_q] = upd_next;
      if (br_cnt_q != CNT_MAX) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (upd_mis_q && (mis_cnt_q != CNT_MAX)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bht_q       <= '{default: BP_NTS};
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
      upd_mis_q   <= 1'b0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      bht_q       <= bht_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
      upd_taken_q <= upd_taken_d;
      upd_mis_q   <= upd_mis_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;

`ifdef BHT_BTB_EN
  logic             btb_valid_q  [ENTRIES];
  logic             btb_valid_d  [ENTRIES];
  logic [TAG_W-1:0] btb_tag_q    [ENTRIES];
  logic [TAG_W-1:0] btb_tag_d    [ENTRIES];
  logic [PC_W-1:0]  btb_target_q [ENTRIES];
  logic [PC_W-1:0]  btb_target_d [ENTRIES];
  logic [TAG_W-1:0] upd_tag_q, upd_tag_d;
  logic [PC_W-1:0]  upd_target_q, upd_target_d;
  logic [TAG_W-1:0] if_tag;
  logic             lk_valid;
  logic [TAG_W-1:0] lk_tag;
  logic [PC_W-1:0]  lk_target;
  logic             btb_fwd;

  assign if_tag  = if_pc[IDX_W+TAG_W+BP_IDX_LSB-1:IDX_W+BP_IDX_LSB];
  assign btb_fwd = fwd_hit & upd_taken_q;

  always_comb begin
    upd_tag_d    = ex_pc[IDX_W+TAG_W+BP_IDX_LSB-1:IDX_W+BP_IDX_LSB];
    upd_target_d = ex_target;
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    if (upd_valid_q && upd_taken_q) begin
      btb_valid_d[upd_idx_q]  = 1'b1;
      btb_tag_d[upd_idx_q]    = upd_tag_q;
      btb_target_d[upd_idx_q] = upd_target_q;
    end
  end

  always_comb begin
    lk_valid  = btb_valid_q[if_idx];
    lk_tag    = btb_tag_q[if_idx];
    lk_target = btb_target_q[if_idx];
    if (btb_fwd) begin
      lk_valid  = 1'b1;
      lk_tag    = upd_tag_q;
      lk_target = upd_target_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid_q  <= '{default: 1'b0};
      btb_tag_q    <= '{default: '0};
      btb_target_q <= '{default: '0};
      upd_tag_q    <= '0;
      upd_target_q <= '0;
    end else begin
      btb_valid_q  <= btb_valid_d;
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
      upd_tag_q    <= upd_tag_d;
      upd_target_q <= upd_target_d;
    end
  end

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    if (!rst) begin
      pred_taken  = if_valid & lk_valid & (lk_tag == if_tag) & lk_state[1];
      pred_target = lk_target;
    end
  end
`else
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    if (!rst) pred_taken = if_valid & lk_state[1];
  end
`endif

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (!rst) begin
      redirect    = mispredict;
      redirect_pc = ex_taken ? ex_target : (ex_pc + PC_W'(4));
    end
  end

endmodule
